// File: rtl/pipe_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: next-PC select codes,
// fetch FSM states and default constants.
package pipe_fetch_unit_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JR  = 2'b10,
        PCSRC_J   = 2'b11
    } pcsrc_e;

    typedef enum logic {
        S_REQ   = 1'b0,
        S_VALID = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;

    // 32-bit wrap-around increment; no alignment check on purpose
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pipe_fetch_unit_npc_mux.sv
// Combinational 4:1 next-PC select between sequential, branch, register
// jump and jump targets.
module npc_mux
    import pipe_fetch_unit_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] npc
);

    // Select the next PC source
    always_comb begin
        npc = pc_plus4;
        case (sel)
            PCSRC_SEQ: npc = pc_plus4;
            PCSRC_BR:  npc = bpc;
            PCSRC_JR:  npc = rpc;
            PCSRC_J:   npc = jpc;
            default:   npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pipe_fetch_unit.sv
// IF stage: PC register, req/ack instruction fetch FSM with in-flight
// redirect kill, and the instruction buffer presented to IF/ID.
module pipe_fetch_unit
    import pipe_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic        bubble
);

    fetch_state_e state_r, state_s;
    logic [31:0]  pc_r, pc_s;
    logic         kill_r, kill_s;
    logic [31:0]  redirect_pc_r, redirect_pc_s;
    logic [31:0]  ibuf_r, ibuf_s;
    logic [31:0]  pc4_r, pc4_s;
    logic [31:0]  pc_plus4_s;
    logic [31:0]  npc_s;
    logic         redir_s;

    assign pc_plus4_s = pc_inc(pc_r);
    // A redirect only counts when ID is not stalling; reset masks it so bubble reads 1
    assign redir_s    = wpcir & (pcsource != PCSRC_SEQ) & ~reset;
    assign bubble     = ~redir_s;

    npc_mux u_npc_mux (
        .sel      (pcsource),
        .pc_plus4 (pc_plus4_s),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .npc      (npc_s)
    );

    // Next-state logic for the fetch FSM, PC, kill tracking and buffers
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        kill_s        = kill_r;
        redirect_pc_s = redirect_pc_r;
        ibuf_s        = ibuf_r;
        pc4_s         = pc4_r;
        case (state_r)
            S_REQ: begin
                if (imem_ack) begin
                    if (kill_r) begin
                        pc_s   = redir_s ? npc_s : redirect_pc_r;
                        kill_s = 1'b0;
                    end else if (redir_s) begin
                        pc_s = npc_s;
                    end else begin
                        ibuf_s  = imem_rdata;
                        pc4_s   = pc_plus4_s;
                        state_s = S_VALID;
                    end
                end else if (redir_s) begin
                    // pc must stay put while the request is outstanding
                    redirect_pc_s = npc_s;
                    kill_s        = 1'b1;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_VALID: begin
                if (wpcir) begin
                    pc_s    = npc_s;
                    state_s = S_REQ;
                end else begin
                    state_s = S_VALID;
                end
            end
            default: begin
                state_s = S_REQ;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= S_REQ;
            pc_r          <= RESET_PC;
            kill_r        <= 1'b0;
            redirect_pc_r <= 32'h0000_0000;
            ibuf_r        <= NOP_INST;
            pc4_r         <= pc_inc(RESET_PC);
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            kill_r        <= kill_s;
            redirect_pc_r <= redirect_pc_s;
            ibuf_r        <= ibuf_s;
            pc4_r         <= pc4_s;
        end
    end

    // Output decode from the FSM state
    always_comb begin
        imem_addr = pc_r;
        pc4       = pc4_r;
        if (state_r == S_VALID) begin
            imem_req  = 1'b0;
            ins       = ibuf_r;
            ins_valid = 1'b1;
        end else begin
            imem_req  = 1'b1;
            ins       = NOP_INST;
            ins_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed bench for pipe_fetch_unit with a variable-latency memory model
// returning 0x2000_0000 + address.
module tb_pipe_fetch_unit;

    logic        clock;
    logic        reset;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc4;
    logic [31:0] ins;
    logic        ins_valid;
    logic        bubble;

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    int mem_cnt;

    pipe_fetch_unit dut (
        .clock      (clock),
        .reset      (reset),
        .wpcir      (wpcir),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc4        (pc4),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .bubble     (bubble)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory: acks once a request has waited mem_lat cycles
    always @(posedge clock or posedge reset) begin
        if (reset)
            mem_cnt <= 0;
        else if (imem_req && !imem_ack)
            mem_cnt <= mem_cnt + 1;
        else
            mem_cnt <= 0;
    end
    assign imem_ack   = imem_req && (mem_cnt >= mem_lat);
    assign imem_rdata = 32'h2000_0000 + imem_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
        bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
        #12;
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins", ins, 32'h0);
        chk("rst_pc4", pc4, 32'h4);
        chk("rst_bubble", 32'(bubble), 32'd1);
        reset = 1'b0;
        #1;
        chk("seq_req0", 32'(imem_req), 32'd1);
        chk("seq_addr0", imem_addr, 32'h0);
        chk("seq_ack0", 32'(imem_ack), 32'd1);
        tick();
        chk("seq_valid0", 32'(ins_valid), 32'd1);
        chk("seq_ins0", ins, 32'h2000_0000);
        chk("seq_pc4_0", pc4, 32'h4);
        chk("seq_noreq0", 32'(imem_req), 32'd0);
        chk("seq_bubble0", 32'(bubble), 32'd1);
        tick();
        chk("seq_addr4", imem_addr, 32'h4);
        tick();
        chk("seq_ins4", ins, 32'h2000_0004);
        chk("seq_pc4_4", pc4, 32'h8);
        tick();
        chk("seq_addr8", imem_addr, 32'h8);
        tick();
        chk("seq_ins8", ins, 32'h2000_0008);

        // Stall in S_VALID for three cycles, with a redirect presented but ignored
        wpcir = 1'b0; pcsource = 2'b01; bpc = 32'h0000_0080;
        #1;
        chk("stall_bubble", 32'(bubble), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ins", ins, 32'h2000_0008);
            chk("stall_noreq", 32'(imem_req), 32'd0);
        end
        wpcir = 1'b1; pcsource = 2'b00;
        tick();
        chk("stall_rel_addr", imem_addr, 32'hC);
        chk("stall_rel_nop", ins, 32'h0);
        chk("stall_rel_invalid", 32'(ins_valid), 32'd0);
        tick();
        chk("seq_insC", ins, 32'h2000_000C);
        chk("seq_pc4_C", pc4, 32'h10);

        // Branch redirect while valid
        pcsource = 2'b01; bpc = 32'h40;
        #1;
        chk("br_bubble0", 32'(bubble), 32'd0);
        tick();
        pcsource = 2'b00;
        #1;
        chk("br_bubble1", 32'(bubble), 32'd1);
        chk("br_addr", imem_addr, 32'h40);
        tick();
        chk("br_ins", ins, 32'h2000_0040);
        chk("br_pc4", pc4, 32'h44);

        // Jump redirect while a 3-wait fetch at 0x10 is in flight
        mem_lat = 3; pcsource = 2'b10; rpc = 32'h10;
        tick();
        pcsource = 2'b00;
        #1;
        chk("fl_addr0", imem_addr, 32'h10);
        chk("fl_ack0", 32'(imem_ack), 32'd0);
        tick();
        pcsource = 2'b11; jpc = 32'h100;
        #1;
        chk("fl_bubble", 32'(bubble), 32'd0);
        tick();
        pcsource = 2'b00;
        #1;
        chk("fl_addr2", imem_addr, 32'h10);
        chk("fl_invalid2", 32'(ins_valid), 32'd0);
        tick();
        chk("fl_ack3", 32'(imem_ack), 32'd1);
        chk("fl_addr3", imem_addr, 32'h10);
        tick();
        mem_lat = 0;
        #1;
        chk("fl_discard_invalid", 32'(ins_valid), 32'd0);
        chk("fl_new_addr", imem_addr, 32'h100);
        tick();
        chk("fl_new_ins", ins, 32'h2000_0100);

        // Two redirects before the ack: the later one wins
        mem_lat = 4;
        tick();
        chk("dbl_addr0", imem_addr, 32'h104);
        pcsource = 2'b10; rpc = 32'h200;
        tick();
        pcsource = 2'b01; bpc = 32'h300;
        tick();
        pcsource = 2'b00;
        #1;
        chk("dbl_addr_hold", imem_addr, 32'h104);
        tick();
        tick();
        chk("dbl_ack", 32'(imem_ack), 32'd1);
        tick();
        chk("dbl_addr_new", imem_addr, 32'h300);
        chk("dbl_invalid", 32'(ins_valid), 32'd0);

        // Redirect landing in the ack cycle with no earlier kill
        mem_lat = 2;
        tick();
        tick();
        pcsource = 2'b11; jpc = 32'h500;
        #1;
        chk("same_ack", 32'(imem_ack), 32'd1);
        chk("same_bubble", 32'(bubble), 32'd0);
        tick();
        pcsource = 2'b00; mem_lat = 0;
        #1;
        chk("same_addr", imem_addr, 32'h500);
        chk("same_invalid", 32'(ins_valid), 32'd0);
        tick();
        chk("same_ins", ins, 32'h2000_0500);
        chk("same_pc4", pc4, 32'h504);

        // Asynchronous reset while waiting on a fetch at 0x24
        mem_lat = 5; pcsource = 2'b01; bpc = 32'h24;
        tick();
        pcsource = 2'b00;
        #1;
        chk("ar_addr", imem_addr, 32'h24);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("ar_ins_valid", 32'(ins_valid), 32'd0);
        chk("ar_ins", ins, 32'h0);
        chk("ar_pc4", pc4, 32'h4);
        chk("ar_addr_rst", imem_addr, 32'h0);
        #1;
        reset = 1'b0; mem_lat = 0;
        #1;
        chk("ar_req", 32'(imem_req), 32'd1);
        chk("ar_first_addr", imem_addr, 32'h0);
        tick();
        chk("ar_ins_after", ins, 32'h2000_0000);

        // PC wrap-around at the top of the address space
        pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
        tick();
        pcsource = 2'b00;
        #1;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_ins", ins, 32'h1FFF_FFFC);
        chk("wrap_pc4", pc4, 32'h0);
        tick();
        chk("wrap_next_addr", imem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
